// File: rtl/clock_pkg.sv
// Shared constants and preset clamping for the min/sec timebase.
// Both BCD counters use this package.
package clock_pkg;

    localparam int UNITS_W        = 4;
    localparam int TENS_W         = 3;
    localparam int DEFAULT_CLK_HZ = 50_000_000;

    localparam logic [UNITS_W-1:0] UNITS_MAX  = 4'd9;
    localparam logic [TENS_W-1:0]  TENS60_MAX = 3'd5;

    // An out-of-range preset digit loads zero. Each digit is judged on its own.
    function automatic logic [UNITS_W-1:0] clamp_units(input logic [UNITS_W-1:0] d);
        return (d > UNITS_MAX) ? '0 : d;
    endfunction

    function automatic logic [TENS_W-1:0] clamp_tens(input logic [TENS_W-1:0] d);
        return (d > TENS60_MAX) ? '0 : d;
    endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter, modulo 60, with preset and clear.
// When a load, zero and inc arrive together, load wins, then zero, then inc.
module bcd_mod60
    import clock_pkg::*;
(
    input  logic               clk,
    input  logic               clr_n,
    input  logic               inc,
    input  logic               zero,
    input  logic               load,
    input  logic [UNITS_W-1:0] d0,
    input  logic [TENS_W-1:0]  d1,
    output logic [UNITS_W-1:0] q0,
    output logic [TENS_W-1:0]  q1,
    output logic               wrap
);

    logic [UNITS_W-1:0] q0_reg;
    logic [TENS_W-1:0]  q1_reg;
    logic               units_top;
    logic               tens_top;

    assign units_top = (q0_reg == UNITS_MAX);
    assign tens_top  = (q1_reg == TENS60_MAX);

    // Combinational so that the next stage counts on the same edge.
    assign wrap = inc && units_top && tens_top;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q0_reg <= '0;
            q1_reg <= '0;
        end else if (load) begin
            q0_reg <= clamp_units(d0);
            q1_reg <= clamp_tens(d1);
        end else if (zero) begin
            q0_reg <= '0;
            q1_reg <= '0;
        end else if (inc) begin
            if (units_top) begin
                q0_reg <= '0;
                q1_reg <= tens_top ? '0 : q1_reg + TENS_W'(1);
            end else begin
                q0_reg <= q0_reg + UNITS_W'(1);
            end
        end
    end

    assign q0 = q0_reg;
    assign q1 = q1_reg;

endmodule

// File: rtl/min_sec_timebase.sv
// 1 Hz prescaler plus BCD seconds and minutes, with an hour-enable pulse,
// minute preset, seconds clear and a colon blink.
module min_sec_timebase
    import clock_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               run,
    input  logic               sec_clr,
    input  logic               load,
    input  logic [UNITS_W-1:0] d_m0,
    input  logic [TENS_W-1:0]  d_m1,
    output logic [UNITS_W-1:0] s0,
    output logic [TENS_W-1:0]  s1,
    output logic [UNITS_W-1:0] m0,
    output logic [TENS_W-1:0]  m1,
    output logic               tick_1hz,
    output logic               hour_en,
    output logic               blink
);

    localparam int               PRE_W    = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2);

    logic [PRE_W-1:0] pre_reg;
    logic [PRE_W-1:0] pre_next;
    logic             tick_reg;
    logic             hour_reg;
    logic             blink_reg;
    logic             tick_now;
    logic             sec_wrap;
    logic             min_wrap;
    logic             restart;

    // Either control input restarts the second, and any tick on that edge is dropped.
    assign restart  = load || sec_clr;
    assign tick_now = run && !restart && (pre_reg == PRE_MAX);

    always_comb begin
        pre_next = pre_reg;
        if (restart) begin
            pre_next = '0;
        end else if (run) begin
            pre_next = (pre_reg == PRE_MAX) ? '0 : pre_reg + PRE_W'(1);
        end
    end

    // blink is computed from pre_next, so the registered value lines up
    // with the prescaler count it describes.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pre_reg   <= '0;
            tick_reg  <= 1'b0;
            hour_reg  <= 1'b0;
            blink_reg <= 1'b0;
        end else begin
            pre_reg   <= pre_next;
            tick_reg  <= tick_now;
            hour_reg  <= min_wrap;
            blink_reg <= (pre_next >= PRE_HALF);
        end
    end

    bcd_mod60 u_sec (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (tick_now),
        .zero  (restart),
        .load  (1'b0),
        .d0    ('0),
        .d1    ('0),
        .q0    (s0),
        .q1    (s1),
        .wrap  (sec_wrap)
    );

    // sec_wrap is already gated by restart, so load can never raise min_wrap.
    bcd_mod60 u_min (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (sec_wrap),
        .zero  (1'b0),
        .load  (load),
        .d0    (d_m0),
        .d1    (d_m1),
        .q0    (m0),
        .q1    (m1),
        .wrap  (min_wrap)
    );

    assign tick_1hz = tick_reg;
    assign hour_en  = hour_reg;
    assign blink    = blink_reg;

endmodule
